// File: rtl/req_capture.sv
// req_capture: request-capture stage ahead of a WIDTH-input priority encoder.
// Samples WIDTH request lines and detects their rising edges. Each event is
// held in a sticky pending bit until it is acknowledged by index. Repeat
// events on a line that is still pending set a sticky overrun flag.
//
// Configuration macro:
//   REQ_CAPTURE_SYNC_EN - defined  : two-flop synchronizer per line
//                                    (3-edge latency).
//                         undefined: single sample flop
//                                    (2-edge latency).
//
// Ports:
//   clk      in           rising-edge clock
//   rst      in           asynchronous active-high reset
//   req      in  [W-1:0]  level request lines; an event is a 0->1 transition
//   mask_wr  in           load mask_in into the mask register
//   mask_in  in  [W-1:0]  new mask value (1 = line disabled)
//   ack      in           clear the pending bit selected by ack_id
//   ack_id   in  [IDW-1:0] index of the pending bit to clear
//   d        out [W-1:0]  pend & ~mask, to the encoder d input
//   pend     out [W-1:0]  raw pending register
//   mask     out [W-1:0]  current mask register
//   irq      out          |d
//   ovf      out [W-1:0]  sticky per-line overrun flags
module req_capture #(
  parameter  int IDW   = 2,
  localparam int WIDTH = 2 ** IDW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             mask_wr,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             ack,
  input  logic [IDW-1:0]   ack_id,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] pend,
  output logic [WIDTH-1:0] mask,
  output logic             irq,
  output logic [WIDTH-1:0] ovf
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ovf;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_ack_vec;
  logic [WIDTH-1:0] w_ovr;
  logic [WIDTH-1:0] w_pend_nxt;
  logic [WIDTH-1:0] w_ovf_nxt;

`ifdef REQ_CAPTURE_SYNC_EN
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= req;
      r_s2 <= r_s1;
    end
  end

  assign w_s = r_s2;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
    end else begin
      r_s1 <= req;
    end
  end

  assign w_s = r_s1;
`endif

  // History resets to 0, so a line already high at reset release
  // still yields one event.
  assign w_edge    = w_s & ~r_hist;
  assign w_ack_vec = ack ? (WIDTH'(1) << ack_id) : '0;

  // Set wins over clear; an edge that coincides with an ack to the
  // same line is a fresh event, not an overrun.
  assign w_ovr      = w_edge & r_pend & ~w_ack_vec;
  assign w_pend_nxt = w_edge | (r_pend & ~w_ack_vec);
  assign w_ovf_nxt  = w_ovr | (r_ovf & ~w_ack_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
      r_mask <= '0;
    end else begin
      r_hist <= w_s;
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
      if (mask_wr) begin
        r_mask <= mask_in;
      end
    end
  end

  assign pend = r_pend;
  assign mask = r_mask;
  assign ovf  = r_ovf;
  assign d    = r_pend & ~r_mask;
  assign irq  = |d;

endmodule
